// File: rtl/oled_pkg.sv
// Shared encodings, command ROMs and default timing for the OLED power-up controller.
package oled_pkg;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_VDD_WAIT,
      ST_RES_LOW,
      ST_PRE_CMD,
      ST_VBAT_WAIT,
      ST_POST_CMD,
      ST_READY,
      ST_DATA
   } oled_state_e;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_LOAD,
      PH_WAIT
   } hs_phase_e;

   localparam int DEF_VDD_WAIT_CYC  = 100000;
   localparam int DEF_RES_LOW_CYC   = 300;
   localparam int DEF_VBAT_WAIT_CYC = 10000000;

   localparam int PRE_LEN  = 5;
   localparam int POST_LEN = 7;

   // Byte 0 sits in the least significant position of each ROM word.
   localparam logic [8*PRE_LEN-1:0] PRE_CMD_ROM =
      {8'hF1, 8'hD9, 8'h14, 8'h8D, 8'hAE};
   localparam logic [8*POST_LEN-1:0] POST_CMD_ROM =
      {8'hAF, 8'h00, 8'hDA, 8'hC0, 8'hA0, 8'h0F, 8'h81};

   function automatic logic [7:0] pre_cmd_byte(input logic [2:0] idx);
      logic [7:0] b;
      b = 8'h00;
      for (int i = 0; i < PRE_LEN; i++) begin
         if (int'(idx) == i) b = PRE_CMD_ROM[8*i +: 8];
      end
      return b;
   endfunction

   function automatic logic [7:0] post_cmd_byte(input logic [2:0] idx);
      logic [7:0] b;
      b = 8'h00;
      for (int i = 0; i < POST_LEN; i++) begin
         if (int'(idx) == i) b = POST_CMD_ROM[8*i +: 8];
      end
      return b;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/oled_delay_timer.sv
// Loadable down-counter; expired is the terminal-count compare, so a load of N
// expires exactly N clock edges after the load edge.
module oled_delay_timer
   import oled_pkg::*;
#(
   parameter int WIDTH = 24
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   output logic             expired
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = value;
      end else if (count_q != '0) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == WIDTH'(1));

endmodule

// File: rtl/oled_ctrl.sv
// OLED panel power sequencer and command/data byte feeder for an SPI transmitter.
//
// state        | meaning
// OFF          | supplies off, waiting for start
// VDD_WAIT     | logic supply on, settling delay
// RES_LOW      | panel reset held low
// PRE_CMD      | sending pre-VBAT command bytes
// VBAT_WAIT    | panel supply on, settling delay
// POST_CMD     | sending post-VBAT command bytes
// READY        | idle, offering data_ready to the host
// DATA         | sending one latched host data byte
module oled_ctrl
   import oled_pkg::*;
#(
   parameter int VDD_WAIT_CYC  = DEF_VDD_WAIT_CYC,
   parameter int RES_LOW_CYC   = DEF_RES_LOW_CYC,
   parameter int VBAT_WAIT_CYC = DEF_VBAT_WAIT_CYC
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       data_valid,
   input  logic [7:0] data_byte,
   output logic       data_ready,
   output logic       init_done,
   output logic [7:0] spi_byte,
   output logic       spi_load,
   input  logic       spi_done,
   output logic       oled_dc,
   output logic       oled_res_n,
   output logic       oled_vdd_n,
   output logic       oled_vbat_n
);

   localparam int TMR_W = $clog2(max3(VDD_WAIT_CYC, RES_LOW_CYC, VBAT_WAIT_CYC) + 1);

   oled_state_e state_q, state_d;
   hs_phase_e   phase_q, phase_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  spi_byte_q, spi_byte_d;
   logic        spi_load_q, spi_load_d;
   logic        dc_q, dc_d;
   logic        res_n_q, res_n_d;
   logic        vdd_n_q, vdd_n_d;
   logic        vbat_n_q, vbat_n_d;
   logic        data_ready_q, data_ready_d;
   logic        init_done_q, init_done_d;

   logic             tmr_load;
   logic [TMR_W-1:0] tmr_value;
   logic             tmr_expired;
   logic [7:0]       cmd_byte;
   logic             cmd_last;

   oled_delay_timer #(.WIDTH(TMR_W)) u_timer (
      .clock   (clock),
      .reset   (reset),
      .load    (tmr_load),
      .value   (tmr_value),
      .expired (tmr_expired)
   );

   always_comb begin
      cmd_byte = 8'h00;
      cmd_last = 1'b0;
      if (state_q == ST_PRE_CMD) begin
         cmd_byte = pre_cmd_byte(idx_q);
         cmd_last = (idx_q == 3'(PRE_LEN - 1));
      end else begin
         cmd_byte = post_cmd_byte(idx_q);
         cmd_last = (idx_q == 3'(POST_LEN - 1));
      end
   end

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      idx_d        = idx_q;
      spi_byte_d   = spi_byte_q;
      spi_load_d   = spi_load_q;
      dc_d         = dc_q;
      res_n_d      = res_n_q;
      vdd_n_d      = vdd_n_q;
      vbat_n_d     = vbat_n_q;
      data_ready_d = 1'b0;
      init_done_d  = init_done_q;
      tmr_load     = 1'b0;
      tmr_value    = '0;

      case (state_q)
         ST_OFF: begin
            if (start) begin
               vdd_n_d   = 1'b0;
               tmr_load  = 1'b1;
               tmr_value = TMR_W'(VDD_WAIT_CYC);
               state_d   = ST_VDD_WAIT;
            end
         end
         ST_VDD_WAIT: begin
            if (tmr_expired) begin
               res_n_d   = 1'b0;
               tmr_load  = 1'b1;
               tmr_value = TMR_W'(RES_LOW_CYC);
               state_d   = ST_RES_LOW;
            end
         end
         ST_RES_LOW: begin
            if (tmr_expired) begin
               res_n_d = 1'b1;
               idx_d   = 3'd0;
               phase_d = PH_IDLE;
               state_d = ST_PRE_CMD;
            end
         end
         ST_PRE_CMD, ST_POST_CMD: begin
            case (phase_q)
               PH_IDLE: begin
                  // The byte goes out one cycle before spi_load so it is stable when load rises.
                  if (!spi_done) begin
                     spi_byte_d = cmd_byte;
                     dc_d       = 1'b0;
                     phase_d    = PH_LOAD;
                  end
               end
               PH_LOAD: begin
                  spi_load_d = 1'b1;
                  phase_d    = PH_WAIT;
               end
               default: begin
                  if (spi_done) begin
                     spi_load_d = 1'b0;
                     phase_d    = PH_IDLE;
                     if (!cmd_last) begin
                        idx_d = idx_q + 3'd1;
                     end else if (state_q == ST_PRE_CMD) begin
                        idx_d     = 3'd0;
                        vbat_n_d  = 1'b0;
                        tmr_load  = 1'b1;
                        tmr_value = TMR_W'(VBAT_WAIT_CYC);
                        state_d   = ST_VBAT_WAIT;
                     end else begin
                        idx_d       = 3'd0;
                        init_done_d = 1'b1;
                        state_d     = ST_READY;
                     end
                  end
               end
            endcase
         end
         ST_VBAT_WAIT: begin
            if (tmr_expired) begin
               idx_d   = 3'd0;
               phase_d = PH_IDLE;
               state_d = ST_POST_CMD;
            end
         end
         ST_READY: begin
            if (data_valid && data_ready_q) begin
               spi_byte_d = data_byte;
               dc_d       = 1'b1;
               phase_d    = PH_LOAD;
               state_d    = ST_DATA;
            end else begin
               data_ready_d = !spi_done;
            end
         end
         ST_DATA: begin
            if (phase_q == PH_LOAD) begin
               spi_load_d = 1'b1;
               phase_d    = PH_WAIT;
            end else if (spi_done) begin
               spi_load_d = 1'b0;
               phase_d    = PH_IDLE;
               state_d    = ST_READY;
            end
         end
         default: begin
            state_d = ST_OFF;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_OFF;
         phase_q      <= PH_IDLE;
         idx_q        <= 3'd0;
         spi_byte_q   <= 8'h00;
         spi_load_q   <= 1'b0;
         dc_q         <= 1'b0;
         res_n_q      <= 1'b1;
         vdd_n_q      <= 1'b1;
         vbat_n_q     <= 1'b1;
         data_ready_q <= 1'b0;
         init_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         idx_q        <= idx_d;
         spi_byte_q   <= spi_byte_d;
         spi_load_q   <= spi_load_d;
         dc_q         <= dc_d;
         res_n_q      <= res_n_d;
         vdd_n_q      <= vdd_n_d;
         vbat_n_q     <= vbat_n_d;
         data_ready_q <= data_ready_d;
         init_done_q  <= init_done_d;
      end
   end

   assign spi_byte    = spi_byte_q;
   assign spi_load    = spi_load_q;
   assign oled_dc     = dc_q;
   assign oled_res_n  = res_n_q;
   assign oled_vdd_n  = vdd_n_q;
   assign oled_vbat_n = vbat_n_q;
   assign data_ready  = data_ready_q;
   assign init_done   = init_done_q;

endmodule

// File: tb/tb_oled_ctrl.sv
// Bench for oled_ctrl: SPI transmitter model, frame scoreboard and directed power-up/data steps.
module tb_oled_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       data_valid = 1'b0;
   logic [7:0] data_byte = 8'h00;
   logic       data_ready, init_done, oled_dc, oled_res_n, oled_vdd_n, oled_vbat_n;
   logic [7:0] data_in;
   logic       load_data;
   logic       done_send;

   oled_ctrl #(
      .VDD_WAIT_CYC  (20),
      .RES_LOW_CYC   (5),
      .VBAT_WAIT_CYC (50)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .data_valid  (data_valid),
      .data_byte   (data_byte),
      .data_ready  (data_ready),
      .init_done   (init_done),
      .spi_byte    (data_in),
      .spi_load    (load_data),
      .spi_done    (done_send),
      .oled_dc     (oled_dc),
      .oled_res_n  (oled_res_n),
      .oled_vdd_n  (oled_vdd_n),
      .oled_vbat_n (oled_vbat_n)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;
   logic [8:0] sb[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // SPI transmitter model: 8-cycle frame, done held until load falls.
   logic       busy = 1'b0, done_int = 1'b0, frame_done = 1'b0, force_done = 1'b0;
   logic [3:0] cnt = 4'd0;
   logic [7:0] cap_byte = 8'h00;
   logic       cap_dc = 1'b0;
   assign done_send = done_int | force_done;

   always @(posedge clock) begin
      if (reset) begin
         busy <= 1'b0; done_int <= 1'b0; frame_done <= 1'b0; cnt <= 4'd0;
      end else begin
         frame_done <= 1'b0;
         if (done_int && !load_data) done_int <= 1'b0;
         if (!busy && !done_int && load_data) begin
            busy <= 1'b1; cnt <= 4'd8; cap_byte <= data_in; cap_dc <= oled_dc;
         end else if (busy) begin
            if (cnt == 4'd1) begin
               busy <= 1'b0; done_int <= 1'b1; frame_done <= 1'b1;
            end
            cnt <= cnt - 4'd1;
         end
      end
   end

   int   t_vdd = 0, t_res_f = 0, t_res_r = 0, t_vbat = 0, t_first_load = 0, t_post_load = 0;
   int   last_rise = 0;
   logic prev_vdd = 1'b1, prev_res = 1'b1, prev_vbat = 1'b1, prev_load = 1'b0;

   always @(negedge clock) begin
      logic [8:0] e;
      check("rdy_excl", {31'd0, data_ready & (load_data | done_send)}, 32'd0);
      if (prev_vdd && !oled_vdd_n) t_vdd = cyc;
      if (prev_res && !oled_res_n) t_res_f = cyc;
      if (!prev_res && oled_res_n) t_res_r = cyc;
      if (prev_vbat && !oled_vbat_n) t_vbat = cyc;
      if (!prev_load && load_data) begin
         if (last_rise < t_res_r) t_first_load = cyc;
         if (!oled_vbat_n && last_rise < t_vbat) t_post_load = cyc;
         last_rise = cyc;
      end
      if (frame_done) begin
         check("byte_stable", {23'd0, oled_dc, data_in}, {23'd0, cap_dc, cap_byte});
         check("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("frame", {23'd0, cap_dc, cap_byte}, {23'd0, e});
         end
      end
      prev_vdd = oled_vdd_n; prev_res = oled_res_n; prev_vbat = oled_vbat_n; prev_load = load_data;
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_load"},  {31'd0, load_data},   32'd0);
      check({tag, "_byte"},  {24'd0, data_in},     32'd0);
      check({tag, "_dc"},    {31'd0, oled_dc},     32'd0);
      check({tag, "_res"},   {31'd0, oled_res_n},  32'd1);
      check({tag, "_vdd"},   {31'd0, oled_vdd_n},  32'd1);
      check({tag, "_vbat"},  {31'd0, oled_vbat_n}, 32'd1);
      check({tag, "_rdy"},   {31'd0, data_ready},  32'd0);
      check({tag, "_idone"}, {31'd0, init_done},   32'd0);
   endtask

   task automatic push_init_bytes();
      logic [7:0] cmds [12] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1,
                                8'h81, 8'h0F, 8'hA0, 8'hC0, 8'hDA, 8'h00, 8'hAF};
      for (int i = 0; i < 12; i++) sb.push_back({1'b0, cmds[i]});
   endtask

   // Full power-up; with glitch set, start and data_valid are pulsed where they must be ignored.
   task automatic run_init(input bit glitch);
      int  n;
      bit  sg, dg;
      push_init_bytes();
      @(negedge clock) start = 1'b1;
      @(negedge clock) start = 1'b0;
      n = 0; sg = 0; dg = 0;
      while (!init_done && n < 3000) begin
         @(negedge clock);
         n++;
         start = 1'b0;
         data_valid = 1'b0;
         if (glitch && !sg && !oled_vbat_n && !load_data) begin
            start = 1'b1; sg = 1;
         end
         if (glitch && !dg && !oled_vbat_n && load_data) begin
            data_valid = 1'b1; data_byte = 8'h99; dg = 1;
         end
      end
      start = 1'b0;
      data_valid = 1'b0;
      check("init_done", {31'd0, init_done}, 32'd1);
      check("vdd_to_res", t_res_f - t_vdd, 32'd20);
      check("res_low_len", t_res_r - t_res_f, 32'd5);
      check("res_to_load", t_first_load - t_res_r, 32'd2);
      check("vbat_to_post", t_post_load - t_vbat, 32'd52);
      check("init_sb_empty", sb.size(), 32'd0);
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!data_ready && n < 300) begin
         @(negedge clock);
         n++;
      end
      check(tag, {31'd0, data_ready}, 32'd1);
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clock);
         n++;
      end
      check(tag, sb.size(), 32'd0);
   endtask

   initial begin
      logic [7:0] stream [3] = '{8'h55, 8'hAA, 8'hFF};
      int n;

      repeat (3) @(negedge clock);
      check_reset_vals("rst");
      reset = 1'b0;

      run_init(1'b0);

      for (int i = 0; i < 3; i++) sb.push_back({1'b1, stream[i]});
      data_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         data_byte = stream[i];
         wait_ready("stream_ready");
         @(negedge clock);
      end
      data_valid = 1'b0;
      wait_drain("stream_drain");

      // Reset mid-frame while 0x14 is loaded.
      reset = 1'b1;
      @(negedge clock) reset = 1'b0;
      sb.push_back({1'b0, 8'hAE});
      sb.push_back({1'b0, 8'h8D});
      @(negedge clock) start = 1'b1;
      @(negedge clock) start = 1'b0;
      n = 0;
      while (!(load_data && data_in == 8'h14) && n < 2000) begin
         @(negedge clock);
         n++;
      end
      check("abort_reached", {31'd0, load_data && data_in == 8'h14}, 32'd1);
      check("abort_sb_empty", sb.size(), 32'd0);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check_reset_vals("midrst");
      @(negedge clock) reset = 1'b0;

      run_init(1'b1);
      force_done = 1'b1;
      sb.push_back({1'b1, 8'h3C});
      data_byte = 8'h3C;
      data_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         check("force_rdy", {31'd0, data_ready}, 32'd0);
         check("force_load", {31'd0, load_data}, 32'd0);
      end
      force_done = 1'b0;
      wait_ready("force_release_ready");
      @(negedge clock) data_valid = 1'b0;
      wait_drain("force_drain");

      repeat (20) @(negedge clock);
      check("sb_final", sb.size(), 32'd0);
      check("final_init_done", {31'd0, init_done}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
